conductance_leak_engine: RTL and testbench

Multi-cycle, handshaked successor to the combinational conductance leak unit: computes one exponential-decay step gOut = g − g·Δt/τ in signed fixed point. Division is done by a shared sequential restoring divider, and there is a single-cycle power-of-two shift mode. A channel tag is carried through so one engine can serve excitatory and inhibitory conductances for many neurons. It sits between the neuron-state memory read port and the conductance write-back path.

---
 rtl/conductance_leak_engine.sv | 219 +++++++++++++++++++++
 tb/tb_conductance_leak_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conductance_leak_engine.sv
// conductance_leak_engine
// One exponential-decay step gOut = g - g*dt/tau in signed fixed point.
// The magnitude |g|*DeltaT is formed once, then either shifted (tau = 2^s)
// or divided by tau<<DELTAT_WIDTH with a restoring divider that retires one
// numerator bit per cycle. Only one request is in flight at a time.
module conductance_leak_engine #(
  parameter int INTEGER_WIDTH   = 32,
  parameter int DATA_WIDTH_FRAC = 32,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int DELTAT_WIDTH    = 4,
  parameter int TAG_WIDTH       = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [DATA_WIDTH-1:0]    InG,
  input  logic [DELTAT_WIDTH-1:0]  InDeltaT,
  input  logic [INTEGER_WIDTH-1:0] InTau,
  input  logic                     InMode,
  input  logic [TAG_WIDTH-1:0]     InTag,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [DATA_WIDTH-1:0]    OutG,
  output logic [TAG_WIDTH-1:0]     OutTag,
  output logic                     OutErr
);

  localparam int NW    = DATA_WIDTH + DELTAT_WIDTH;
  localparam int CNT_W = $clog2(NW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Captured request
  logic [DATA_WIDTH-1:0]    g_q, g_d;
  logic [DELTAT_WIDTH-1:0]  dt_q, dt_d;
  logic [INTEGER_WIDTH-1:0] tau_q, tau_d;
  logic                     mode_q, mode_d;
  logic [TAG_WIDTH-1:0]     tag_q, tag_d;

  // MUL takes two cycles: product register, then mode decision
  logic                     mul_phase_q, mul_phase_d;
  logic [NW-1:0]            n_q, n_d;

  // Divider: num_q shifts numerator bits out of the top and quotient bits in
  // at the bottom, so after NW steps it holds the quotient.
  logic [NW-1:0]            num_q, num_d;
  logic [NW-1:0]            den_q, den_d;
  logic [NW-1:0]            rem_q, rem_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  // Result registers
  logic [DATA_WIDTH-1:0]    out_g_q, out_g_d;
  logic [TAG_WIDTH-1:0]     out_tag_q, out_tag_d;
  logic                     out_err_q, out_err_d;

  // Datapath helpers
  logic [DATA_WIDTH-1:0]    mag;
  logic [NW-1:0]            prod;
  logic [8:0]               shamt;
  logic [DATA_WIDTH-1:0]    shift_res;
  logic                     tau_pos;
  logic [NW-1:0]            den_init;
  logic [NW:0]              rem_sh;
  logic [NW:0]              rem_diff;
  logic                     rem_ge;
  logic [NW-1:0]            rem_nx;
  logic [NW-1:0]            num_nx;
  logic                     div_last;

  // Move g toward zero by q; q < |g| so this never wraps.
  function automatic logic [DATA_WIDTH-1:0] decay(input logic [DATA_WIDTH-1:0] g,
                                                  input logic [DATA_WIDTH-1:0] q);
    return g[DATA_WIDTH-1] ? (g + q) : (g - q);
  endfunction

  // Magnitude, product, shift-mode quotient and one divider step
  always_comb begin
    // Two's-complement negate maps the most-negative value to 2^(DW-1) unsigned
    mag       = g_q[DATA_WIDTH-1] ? (~g_q + DATA_WIDTH'(1)) : g_q;
    prod      = NW'(mag) * NW'(dt_q);
    shamt     = 9'(tau_q[7:0]) + 9'(DELTAT_WIDTH);
    shift_res = (shamt >= 9'(NW)) ? '0 : DATA_WIDTH'(n_q >> shamt);
    tau_pos   = ($signed(tau_q) > 0);
    den_init  = NW'(tau_q) << DELTAT_WIDTH;
    rem_sh    = {rem_q, num_q[NW-1]};
    rem_diff  = rem_sh - {1'b0, den_q};
    rem_ge    = ~rem_diff[NW];
    rem_nx    = rem_ge ? rem_diff[NW-1:0] : rem_sh[NW-1:0];
    num_nx    = {num_q[NW-2:0], rem_ge};
    div_last  = (cnt_q == CNT_W'(NW - 1));
  end

  // Next-state logic for the request FSM and its datapath registers
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    dt_d        = dt_q;
    tau_d       = tau_q;
    mode_d      = mode_q;
    tag_d       = tag_q;
    mul_phase_d = mul_phase_q;
    n_d         = n_q;
    num_d       = num_q;
    den_d       = den_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    out_g_d     = out_g_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;

    case (state_q)
      S_IDLE: begin
        if (InValid) begin
          g_d         = InG;
          dt_d        = InDeltaT;
          tau_d       = InTau;
          mode_d      = InMode;
          tag_d       = InTag;
          out_err_d   = 1'b0;
          mul_phase_d = 1'b0;
          state_d     = S_MUL;
        end
      end

      S_MUL: begin
        if (!mul_phase_q) begin
          n_d         = prod;
          mul_phase_d = 1'b1;
        end else if (mode_q) begin
          out_g_d   = decay(g_q, shift_res);
          out_tag_d = tag_q;
          state_d   = S_OUT;
        end else if (!tau_pos) begin
          // Non-positive tau: pass g through unchanged and flag it
          out_g_d   = g_q;
          out_err_d = 1'b1;
          out_tag_d = tag_q;
          state_d   = S_OUT;
        end else begin
          num_d   = n_q;
          den_d   = den_init;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        num_d = num_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (div_last) begin
          // Upper DELTAT_WIDTH quotient bits are always zero
          out_g_d   = decay(g_q, DATA_WIDTH'(num_nx));
          out_tag_d = tag_q;
          state_d   = S_OUT;
        end
      end

      S_OUT: begin
        if (OutReady) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight request
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      dt_q        <= '0;
      tau_q       <= '0;
      mode_q      <= 1'b0;
      tag_q       <= '0;
      mul_phase_q <= 1'b0;
      n_q         <= '0;
      num_q       <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      out_g_q     <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      dt_q        <= dt_d;
      tau_q       <= tau_d;
      mode_q      <= mode_d;
      tag_q       <= tag_d;
      mul_phase_q <= mul_phase_d;
      n_q         <= n_d;
      num_q       <= num_d;
      den_q       <= den_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      out_g_q     <= out_g_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
    end
  end

  assign InReady  = (state_q == S_IDLE);
  assign OutValid = (state_q == S_OUT);
  assign OutG     = out_g_q;
  assign OutTag   = out_tag_q;
  assign OutErr   = out_err_q;

endmodule

// File: tb/tb_conductance_leak_engine.sv
// Testbench for conductance_leak_engine: directed vector table, hand-written
// backpressure and reset-mid-divide sequences, and randomized requests
// checked against a wide-integer reference model.
module tb_conductance_leak_engine;

  localparam int DW      = 64;
  localparam int DTW     = 4;
  localparam int NW      = DW + DTW;
  localparam int LAT_DIV = NW + 2;
  localparam int LAT_SH  = 2;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [63:0]   InG = '0;
  logic [3:0]    InDeltaT = '0;
  logic [31:0]   InTau = '0;
  logic          InMode = 1'b0;
  logic [7:0]    InTag = '0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [63:0]   OutG;
  logic [7:0]    OutTag;
  logic          OutErr;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  conductance_leak_engine dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .InG(InG), .InDeltaT(InDeltaT), .InTau(InTau), .InMode(InMode), .InTag(InTag),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutG(OutG), .OutTag(OutTag), .OutErr(OutErr)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [63:0] g;
    logic [3:0]  dt;
    logic [31:0] tau;
    logic        mode;
    logic [7:0]  tag;
    logic [63:0] exp_g;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: gOut = g - trunc(g*DeltaT / (16*tau)), signed truncation toward zero
  task automatic model(input logic [63:0] g, input logic [3:0] dt, input logic [31:0] tau,
                       input logic mode, output logic [63:0] eg, output logic ee,
                       output int el);
    logic signed [127:0] gs, dts, prod, dv, q, r;
    int s;
    gs   = {{64{g[63]}}, g};
    dts  = {124'd0, dt};
    prod = gs * dts;
    ee   = 1'b0;
    if (mode) begin
      s  = int'(tau[7:0]);
      el = LAT_SH;
      if (s + DTW >= 100) q = '0;
      else begin
        dv = 128'sd1 <<< (s + DTW);
        q  = prod / dv;
      end
      r  = gs - q;
      eg = r[63:0];
    end else if ($signed(tau) <= 0) begin
      eg = g;
      ee = 1'b1;
      el = LAT_SH;
    end else begin
      dv = {96'd0, tau} * 128'sd16;
      q  = prod / dv;
      r  = gs - q;
      eg = r[63:0];
      el = LAT_DIV;
    end
  endtask

  // Wait for InReady, present one request, accept on the next edge.
  task automatic send(input logic [63:0] g, input logic [3:0] dt, input logic [31:0] tau,
                      input logic mode, input logic [7:0] tag);
    int guard = 0;
    while (!InReady && guard < 300) begin
      @(posedge Clock); #1;
      guard++;
    end
    if (!InReady) begin
      checks++; errors++;
      $display("FAIL ready_timeout: InReady got 0 expected 1");
    end
    InValid = 1'b1; InG = g; InDeltaT = dt; InTau = tau; InMode = mode; InTag = tag;
    @(posedge Clock); #1;
    InValid = 1'b0;
    InG = {$urandom, $urandom}; InDeltaT = 4'($urandom); InTau = $urandom;
    InMode = 1'($urandom); InTag = 8'($urandom);
    chk("err_clear_on_accept", {63'd0, OutErr}, 64'd0);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge Clock); #1;
      lat++;
    end while (!OutValid && lat < 300);
    if (!OutValid) begin
      checks++; errors++;
      $display("FAIL out_timeout: OutValid got 0 expected 1");
    end
  endtask

  task automatic release_out();
    OutReady = 1'b1;
    @(posedge Clock); #1;
    OutReady = 1'b0;
    chk("valid_drop_after_hs", {63'd0, OutValid}, 64'd0);
  endtask

  task automatic run_txn(input logic [63:0] g, input logic [3:0] dt, input logic [31:0] tau,
                         input logic mode, input logic [7:0] tag,
                         input logic [63:0] eg, input logic ee, input int el,
                         input logic early_ready);
    int lat;
    OutReady = early_ready;
    send(g, dt, tau, mode, tag);
    wait_out(lat);
    $display("txn %0d g=%h dt=%0d tau=%h mode=%0d tag=%h -> OutG=%h tag=%h err=%0d lat=%0d",
             txn_no, g, dt, tau, mode, tag, OutG, OutTag, OutErr, lat);
    txn_no++;
    chk("out_g", OutG, eg);
    chk("out_tag", {56'd0, OutTag}, {56'd0, tag});
    chk("out_err", {63'd0, OutErr}, {63'd0, ee});
    chk("latency", 64'(lat), 64'(el));
    release_out();
  endtask

  initial begin
    logic [63:0] g, eg;
    logic [3:0]  dt;
    logic [31:0] tau;
    logic        mode, ee;
    int          el;
    logic [63:0] held_g;

    vecs[0] = '{64'h0000000A_00000000, 4'd8,  32'd5,          1'b0, 8'h3C, 64'h00000009_00000000, 1'b0, LAT_DIV};
    vecs[1] = '{64'hFFFFFFF6_00000000, 4'd8,  32'd5,          1'b0, 8'h11, 64'hFFFFFFF7_00000000, 1'b0, LAT_DIV};
    vecs[2] = '{64'h00000000_00000001, 4'd15, 32'd1,          1'b0, 8'h22, 64'h00000000_00000001, 1'b0, LAT_DIV};
    vecs[3] = '{64'hFFFFFFFF_FFFFFFFF, 4'd15, 32'd1,          1'b0, 8'h33, 64'hFFFFFFFF_FFFFFFFF, 1'b0, LAT_DIV};
    vecs[4] = '{64'h0000000A_00000000, 4'd8,  32'd2,          1'b1, 8'h44, 64'h00000008_C0000000, 1'b0, LAT_SH};
    vecs[5] = '{64'h0000000A_00000000, 4'd8,  32'd80,         1'b1, 8'h55, 64'h0000000A_00000000, 1'b0, LAT_SH};
    vecs[6] = '{64'h0000000A_00000000, 4'd8,  32'd0,          1'b0, 8'h66, 64'h0000000A_00000000, 1'b1, LAT_SH};
    vecs[7] = '{64'h0000000A_00000000, 4'd8,  32'hFFFFFFFD,   1'b0, 8'h77, 64'h0000000A_00000000, 1'b1, LAT_SH};
    // |g| = 2^63, g*15/16 removed leaves g/16 = -2^59
    vecs[8] = '{64'h80000000_00000000, 4'd15, 32'd1,          1'b0, 8'h88, 64'hF8000000_00000000, 1'b0, LAT_DIV};
    vecs[9] = '{64'h00000003_00000000, 4'd0,  32'd7,          1'b0, 8'h99, 64'h00000003_00000000, 1'b0, LAT_DIV};

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_in_ready",  {63'd0, InReady},  64'd1);
    chk("rst_out_valid", {63'd0, OutValid}, 64'd0);
    chk("rst_out_g",     OutG,              64'd0);
    chk("rst_out_tag",   {56'd0, OutTag},   64'd0);
    chk("rst_out_err",   {63'd0, OutErr},   64'd0);
    Reset = 1'b1;
    @(posedge Clock); #1;

    // Directed table
    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].g, vecs[i].dt, vecs[i].tau, vecs[i].mode, vecs[i].tag,
              vecs[i].exp_g, vecs[i].exp_err, vecs[i].exp_lat, 1'b0);

    // Backpressure: hold OutReady low with stray InValid pulses
    OutReady = 1'b0;
    send(64'h0000000A_00000000, 4'd8, 32'd2, 1'b1, 8'hA5);
    wait_out(el);
    held_g = OutG;
    chk("bp_first_g", OutG, 64'h00000008_C0000000);
    for (int c = 0; c < 20; c++) begin
      InValid = 1'($urandom);
      InG = {$urandom, $urandom};
      InTag = 8'($urandom);
      @(posedge Clock); #1;
      chk("bp_valid",    {63'd0, OutValid}, 64'd1);
      chk("bp_in_ready", {63'd0, InReady},  64'd0);
      chk("bp_out_g",    OutG,              held_g);
      chk("bp_out_tag",  {56'd0, OutTag},   64'hA5);
    end
    InValid = 1'b0;
    $display("txn %0d backpressure hold 20 cycles OutG=%h tag=%h", txn_no, OutG, OutTag);
    txn_no++;
    release_out();
    chk("bp_in_ready_after", {63'd0, InReady}, 64'd1);
    repeat (3) @(posedge Clock);
    #1;
    chk("bp_no_phantom", {63'd0, OutValid}, 64'd0);

    // Reset mid-divide
    send(64'h00000123_45678000, 4'd9, 32'd3, 1'b0, 8'h5A);
    repeat (29) @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    chk("mid_rst_in_ready",  {63'd0, InReady},  64'd1);
    chk("mid_rst_out_valid", {63'd0, OutValid}, 64'd0);
    chk("mid_rst_out_g",     OutG,              64'd0);
    chk("mid_rst_out_tag",   {56'd0, OutTag},   64'd0);
    chk("mid_rst_out_err",   {63'd0, OutErr},   64'd0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    $display("txn %0d reset asserted mid-divide", txn_no);
    txn_no++;
    repeat (3) @(posedge Clock);
    #1;
    chk("post_rst_idle", {63'd0, OutValid}, 64'd0);
    run_txn(64'h0000000A_00000000, 4'd8, 32'd5, 1'b0, 8'h3C,
            64'h00000009_00000000, 1'b0, LAT_DIV, 1'b0);

    // Randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: g = {$urandom, $urandom};
        1: g = {{32{1'b0}}, $urandom};
        2: g = {{32{1'b1}}, $urandom};
        default: g = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      dt   = 4'($urandom);
      mode = 1'($urandom);
      if (mode) tau = {$urandom_range(0, 255) << 8} | 32'($urandom_range(0, 90));
      else begin
        case ($urandom_range(0, 4))
          0: tau = 32'($urandom_range(1, 20));
          1: tau = $urandom >> 1;
          2: tau = -32'($urandom_range(0, 5));
          default: tau = 32'($urandom_range(1, 1000));
        endcase
      end
      model(g, dt, tau, mode, eg, ee, el);
      run_txn(g, dt, tau, mode, 8'($urandom), eg, ee, el, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
